// File: rtl/miner_pkg.sv
// miner_pkg: shared types and constants for the miner stream sequencer.
//   ctrl_state_t : sequencer states
//   err_t        : result status code carried in the second result word
//   IDX_*        : word position of each header field inside the input frame
//   status_word  : builds the second result word from found flag and error code
package miner_pkg;

  localparam int HDR_WORDS = 20;

  localparam logic [4:0] IDX_VER    = 5'd0;
  localparam logic [4:0] IDX_PREV   = 5'd1;
  localparam logic [4:0] IDX_MERKLE = 5'd9;
  localparam logic [4:0] IDX_TIME   = 5'd17;
  localparam logic [4:0] IDX_NBITS  = 5'd18;
  localparam logic [4:0] IDX_NONCE  = 5'd19;

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    DRAIN = 3'd1,
    START = 3'd2,
    MINE  = 3'd3,
    SEND0 = 3'd4,
    SEND1 = 3'd5
  } ctrl_state_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_SHORT   = 2'd1,
    ERR_LONG    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_t;

  function automatic logic [31:0] status_word(input logic found, input err_t err);
    return {found, err, 29'b0};
  endfunction

endpackage

// File: rtl/miner_hdr_regs.sv
// miner_hdr_regs: header register file written one 32-bit word at a time.
//   clk, reset          : clock, asynchronous active-high reset
//   we                  : write strobe (one accepted header beat)
//   word_cnt            : position of the beat inside the frame
//   data                : header word
//   blk_version .. blk_nonce : header fields presented to the miner core
// Registers keep their value between jobs; only a new beat overwrites them.
module miner_hdr_regs
  import miner_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [4:0]   word_cnt,
  input  logic [31:0]  data,
  output logic [31:0]  blk_version,
  output logic [255:0] prev_blk_header_hash,
  output logic [255:0] merkle_root_hash,
  output logic [31:0]  blk_time,
  output logic [31:0]  blk_nbits,
  output logic [31:0]  blk_nonce
);

  // Word k of a hash field lands in bits [32k+31:32k].
  logic [2:0] prev_idx;
  logic [2:0] merkle_idx;

  assign prev_idx   = 3'(word_cnt - IDX_PREV);
  assign merkle_idx = 3'(word_cnt - IDX_MERKLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk_version          <= '0;
      prev_blk_header_hash <= '0;
      merkle_root_hash     <= '0;
      blk_time             <= '0;
      blk_nbits            <= '0;
      blk_nonce            <= '0;
    end else if (we) begin
      if (word_cnt == IDX_VER)
        blk_version <= data;
      else if (word_cnt < IDX_MERKLE)
        prev_blk_header_hash[{prev_idx, 5'd0} +: 32] <= data;
      else if (word_cnt < IDX_TIME)
        merkle_root_hash[{merkle_idx, 5'd0} +: 32] <= data;
      else if (word_cnt == IDX_TIME)
        blk_time <= data;
      else if (word_cnt == IDX_NBITS)
        blk_nbits <= data;
      else if (word_cnt == IDX_NONCE)
        blk_nonce <= data;
    end
  end

endmodule

// File: rtl/miner_stream_ctrl.sv
// miner_stream_ctrl: sequencer between the AXI4-Stream slave port and the miner core.
// Collects a 20-word header frame, pulses start, waits for bitcoin_done or the
// watchdog, then returns a 2-word result frame {nonce, status}.
//   clk, reset                       : clock, asynchronous active-high reset
//   s_tdata/s_tvalid/s_tlast/s_tready: header stream in
//   m_tdata/m_tvalid/m_tlast/m_tready: result stream out
//   blk_* , prev/merkle hashes       : header fields to the miner core
//   start                            : one-cycle job start pulse
//   bitcoin_done/found/nonce         : core completion, found/nonce qualified by done
//   busy                             : job in progress (first accepted word .. result sent)
//   fsm_state                        : current sequencer state, for observation
// Handshake: a beat moves on a rising edge where tvalid & tready are both high;
// m_tdata/m_tvalid/m_tlast are registered and held while m_tvalid & !m_tready.
module miner_stream_ctrl
  import miner_pkg::*;
#(
  parameter int                   DATA_W      = 32,
  parameter int                   TIMEOUT_W   = 32,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_MAX = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic [31:0]       blk_version,
  output logic [255:0]      prev_blk_header_hash,
  output logic [255:0]      merkle_root_hash,
  output logic [31:0]       blk_time,
  output logic [31:0]       blk_nbits,
  output logic [31:0]       blk_nonce,
  output logic              start,
  input  logic              bitcoin_done,
  input  logic              bitcoin_found,
  input  logic [31:0]       bitcoin_nonce,
  output logic              busy,
  output logic [2:0]        fsm_state
);

  localparam logic [4:0] LAST_IDX = 5'(HDR_WORDS - 1);

  ctrl_state_t          state_q;
  logic [4:0]           word_cnt;
  logic                 ready_en;   // holds s_tready low for the first cycle out of reset
  logic [TIMEOUT_W-1:0] wdog;
  logic                 found_q;
  err_t                 err_q;
  logic                 s_fire;
  logic                 hdr_we;

  assign s_tready  = ready_en && ((state_q == LOAD) || (state_q == DRAIN));
  assign s_fire    = s_tvalid && s_tready;
  assign hdr_we    = s_fire && (state_q == LOAD);
  assign start     = (state_q == START);
  assign busy      = (state_q != LOAD) || (word_cnt != 5'd0);
  assign fsm_state = state_q;

  miner_hdr_regs u_hdr_regs (
    .clk                  (clk),
    .reset                (reset),
    .we                   (hdr_we),
    .word_cnt             (word_cnt),
    .data                 (s_tdata[31:0]),
    .blk_version          (blk_version),
    .prev_blk_header_hash (prev_blk_header_hash),
    .merkle_root_hash     (merkle_root_hash),
    .blk_time             (blk_time),
    .blk_nbits            (blk_nbits),
    .blk_nonce            (blk_nonce)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= LOAD;
      word_cnt <= '0;
      ready_en <= 1'b0;
      wdog     <= '0;
      found_q  <= 1'b0;
      err_q    <= ERR_OK;
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      case (state_q)
        LOAD: begin
          if (s_fire) begin
            if (word_cnt == LAST_IDX) begin
              if (s_tlast) begin
                state_q <= START;
              end else begin
                err_q   <= ERR_LONG;
                state_q <= DRAIN;
              end
            end else if (s_tlast) begin
              // Short frame: nothing to mine, report straight away.
              err_q    <= ERR_SHORT;
              m_tdata  <= '0;
              m_tvalid <= 1'b1;
              m_tlast  <= 1'b0;
              state_q  <= SEND0;
            end else begin
              word_cnt <= word_cnt + 5'd1;
            end
          end
        end
        DRAIN: begin
          if (s_fire && s_tlast) begin
            m_tdata  <= '0;
            m_tvalid <= 1'b1;
            m_tlast  <= 1'b0;
            state_q  <= SEND0;
          end
        end
        START: begin
          wdog    <= '0;
          state_q <= MINE;
        end
        MINE: begin
          // done is checked first so it wins over a coincident timeout.
          if (bitcoin_done) begin
            found_q  <= bitcoin_found;
            m_tdata  <= bitcoin_nonce;
            m_tvalid <= 1'b1;
            m_tlast  <= 1'b0;
            state_q  <= SEND0;
          end else if (wdog == TIMEOUT_MAX) begin
            err_q    <= ERR_TIMEOUT;
            m_tdata  <= '0;
            m_tvalid <= 1'b1;
            m_tlast  <= 1'b0;
            state_q  <= SEND0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        SEND0: begin
          if (m_tready) begin
            m_tdata <= status_word(found_q, err_q);
            m_tlast <= 1'b1;
            state_q <= SEND1;
          end
        end
        SEND1: begin
          if (m_tready) begin
            m_tdata  <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            found_q  <= 1'b0;
            err_q    <= ERR_OK;
            word_cnt <= '0;
            state_q  <= LOAD;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_miner_stream_ctrl.sv
// Bench for miner_stream_ctrl: header frames in, a small miner-core model that
// answers start with a delayed done, and a result scoreboard fed by exp_q.
module tb_miner_stream_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  s_tdata;
  logic         s_tvalid;
  logic         s_tlast;
  logic         s_tready;
  logic [31:0]  m_tdata;
  logic         m_tvalid;
  logic         m_tlast;
  logic         m_tready;
  logic [31:0]  blk_version;
  logic [255:0] prev_blk_header_hash;
  logic [255:0] merkle_root_hash;
  logic [31:0]  blk_time;
  logic [31:0]  blk_nbits;
  logic [31:0]  blk_nonce;
  logic         start;
  logic         bitcoin_done;
  logic         bitcoin_found;
  logic [31:0]  bitcoin_nonce;
  logic         busy;
  logic [2:0]   fsm_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  miner_stream_ctrl #(
    .DATA_W      (32),
    .TIMEOUT_W   (32),
    .TIMEOUT_MAX (32'd100)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .s_tdata              (s_tdata),
    .s_tvalid             (s_tvalid),
    .s_tlast              (s_tlast),
    .s_tready             (s_tready),
    .m_tdata              (m_tdata),
    .m_tvalid             (m_tvalid),
    .m_tlast              (m_tlast),
    .m_tready             (m_tready),
    .blk_version          (blk_version),
    .prev_blk_header_hash (prev_blk_header_hash),
    .merkle_root_hash     (merkle_root_hash),
    .blk_time             (blk_time),
    .blk_nbits            (blk_nbits),
    .blk_nonce            (blk_nonce),
    .start                (start),
    .bitcoin_done         (bitcoin_done),
    .bitcoin_found        (bitcoin_found),
    .bitcoin_nonce        (bitcoin_nonce),
    .busy                 (busy),
    .fsm_state            (fsm_state)
  );

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- miner core model ----------------
  // done_delay < 0 means the core never finishes.
  int          done_delay = -1;
  int          done_timer = -1;
  logic [31:0] nonce_cfg  = '0;
  logic        found_cfg  = 1'b0;

  always @(negedge clk) begin
    bitcoin_done  = 1'b0;
    bitcoin_nonce = nonce_cfg;
    bitcoin_found = found_cfg;
    if (reset) begin
      done_timer = -1;
    end else if (start) begin
      done_timer = done_delay;
    end else if (done_timer > 0) begin
      done_timer = done_timer - 1;
      if (done_timer == 0) begin
        bitcoin_done = 1'b1;
        done_timer   = -1;
      end
    end
  end

  // ---------------- result scoreboard + m_tready pattern ----------------
  logic [32:0] exp_q[$];
  int          start_cnt  = 0;
  int unsigned start_cyc  = 0;
  int unsigned valid_cyc  = 0;
  logic        prev_valid = 1'b0;
  int unsigned rdy_phase  = 0;
  logic        stalled    = 1'b0;
  logic [32:0] held       = '0;

  // m_tready set here is the value the next rising edge uses, so a beat seen
  // with valid & ready at this negedge transfers on that edge.
  always @(negedge clk) begin
    logic [32:0] e;
    rdy_phase = (rdy_phase + 1) % 8;
    m_tready  = (rdy_phase >= 2);
    if (reset) begin
      stalled    = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (start) begin
        start_cnt++;
        start_cyc = cyc;
      end
      if (m_tvalid && !prev_valid) valid_cyc = cyc;
      prev_valid = m_tvalid;
      if (stalled) check("axis_hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, held});
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("extra_result_beat", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check("result_beat", {m_tlast, m_tdata}, e);
        end
      end
      stalled = m_tvalid && !m_tready;
      held    = {m_tlast, m_tdata};
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_beat(input logic [31:0] d, input logic l);
    int guard = 0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    while (!s_tready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) check("s_tready_wait", {63'd0, s_tready}, 64'd1);
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) drive_beat(base + 32'(i), (i == n - 1));
  endtask

  task automatic push_result(input logic [31:0] nonce, input logic [31:0] status);
    exp_q.push_back({1'b0, nonce});
    exp_q.push_back({1'b1, status});
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("results_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_values();
    check("rst_s_tready", {63'd0, s_tready}, 64'd0);
    check("rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
    check("rst_m_tlast", {63'd0, m_tlast}, 64'd0);
    check("rst_m_tdata", {32'd0, m_tdata}, 64'd0);
    check("rst_start", {63'd0, start}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_state", {61'd0, fsm_state}, 64'd0);
    check("rst_hdr", {32'd0, blk_version | blk_time | blk_nbits | blk_nonce}, 64'd0);
    check("rst_hashes", {63'd0, |{prev_blk_header_hash, merkle_root_hash}}, 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int sc;
    int d;
    logic [31:0] base;
    reset    = 1'b1;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values();
    reset = 1'b0;
    #1 check("s_tready_first_cycle", {63'd0, s_tready}, 64'd0);
    @(negedge clk);
    check("s_tready_after", {63'd0, s_tready}, 64'd1);

    // 1/2: full frame 1..20, core finds 0xDEADBEEF 50 cycles after start
    nonce_cfg = 32'hDEADBEEF; found_cfg = 1'b1; done_delay = 50;
    push_result(32'hDEADBEEF, 32'h8000_0000);
    sc = start_cnt;
    send_frame(20, 32'd1);
    check("hdr_version", {32'd0, blk_version}, 64'd1);
    check("hdr_prev_lo", {32'd0, prev_blk_header_hash[31:0]}, 64'd2);
    check("hdr_prev_hi", {32'd0, prev_blk_header_hash[255:224]}, 64'd9);
    check("hdr_merkle_lo", {32'd0, merkle_root_hash[31:0]}, 64'h0A);
    check("hdr_merkle_hi", {32'd0, merkle_root_hash[255:224]}, 64'h11);
    check("hdr_time", {32'd0, blk_time}, 64'h12);
    check("hdr_nbits", {32'd0, blk_nbits}, 64'h13);
    check("hdr_nonce", {32'd0, blk_nonce}, 64'h14);
    wait_idle();
    check("start_count_t1", 64'(start_cnt - sc), 64'd1);
    check("done_to_valid_lat", 64'(valid_cyc - start_cyc), 64'd51);

    // 3: short frame, then a normal frame
    sc = start_cnt;
    push_result(32'd0, 32'h2000_0000);
    send_frame(5, 32'h100);
    wait_idle();
    check("short_no_start", 64'(start_cnt - sc), 64'd0);
    check("short_version", {32'd0, blk_version}, 64'h100);
    check("short_prev_w3", {32'd0, prev_blk_header_hash[127:96]}, 64'h104);
    check("short_time_kept", {32'd0, blk_time}, 64'h12);
    nonce_cfg = 32'h1234_5678; found_cfg = 1'b0; done_delay = 10;
    push_result(32'h1234_5678, 32'h0);
    send_frame(20, 32'h300);
    wait_idle();
    check("after_short_start", 64'(start_cnt - sc), 64'd1);
    check("after_short_nonce", {32'd0, blk_nonce}, 64'h313);

    // 4: 23-word frame, extra words dropped
    sc = start_cnt;
    push_result(32'd0, 32'h4000_0000);
    send_frame(23, 32'h200);
    wait_idle();
    check("long_no_start", 64'(start_cnt - sc), 64'd0);
    check("long_nonce", {32'd0, blk_nonce}, 64'h213);
    check("long_version", {32'd0, blk_version}, 64'h200);

    // 5: watchdog expiry, then done coinciding with the expiry cycle
    done_delay = -1;
    push_result(32'd0, 32'h6000_0000);
    send_frame(20, 32'h400);
    wait_idle();
    d = int'(valid_cyc - start_cyc);
    check("timeout_latency", {63'd0, (d == 101 || d == 102)}, 64'd1);
    nonce_cfg = 32'hCAFE_F00D; found_cfg = 1'b1; done_delay = 101;
    push_result(32'hCAFE_F00D, 32'h8000_0000);
    send_frame(20, 32'h500);
    wait_idle();

    // 6: random jobs under the m_tready stall pattern
    for (int j = 0; j < 6; j++) begin
      nonce_cfg  = $urandom;
      found_cfg  = 1'($urandom_range(0, 1));
      done_delay = $urandom_range(1, 60);
      base       = $urandom;
      push_result(nonce_cfg, {found_cfg, 31'd0});
      send_frame(20, base);
      check("rand_hdr_nonce", {32'd0, blk_nonce}, {32'd0, base + 32'd19});
      wait_idle();
    end

    // reset while mining: job is lost, no result appears
    done_delay = -1;
    sc = start_cnt;
    send_frame(20, 32'h600);
    begin
      int g = 0;
      while (start_cnt == sc && g < 500) begin
        @(negedge clk);
        g++;
      end
    end
    check("mid_mine_started", 64'(start_cnt - sc), 64'd1);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values();
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("no_result_after_reset", {63'd0, m_tvalid}, 64'd0);
    check("idle_after_reset", {63'd0, busy}, 64'd0);

    nonce_cfg = 32'h0BAD_F00D; found_cfg = 1'b1; done_delay = 20;
    push_result(32'h0BAD_F00D, 32'h8000_0000);
    send_frame(20, 32'h700);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
